pad_input_debounce: RTL and testbench
=====================================

Name: pad_input_debounce

Overview:
- Downstream conditioning stage for a Schmitt-buffered pad input.
- Takes the buffered, asynchronous pad signal and synchronizes it into the `clk` domain.
- Rejects pulses shorter than a programmable qualification time.
- Outputs a clean level plus single-cycle rise/fall event strobes for GPIO/housekeeping logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (minimum 2).
- CNT_W, 8, width of qualification counter and threshold input.
- RESET_VAL, 1'b0, reset value of synchronizer flops and `dout` (pull-up pads use 1'b1).

Ports:
- clk  input  1  block clock.
- reset  input  1  reset; asynchronous assert, active-high.
- en  input  1  filter enable; when 0, `dout` holds.
- din  input  1  asynchronous pad level from the Schmitt buffer output.
- debounce_cnt  input  CNT_W  qualification threshold N; a new level must be stable N+1 cycles. Quasi-static, but may change at any time.
- dout  output  1  debounced, synchronized level.
- rise_pulse  output  1  one-cycle strobe when `dout` goes 0->1.
- fall_pulse  output  1  one-cycle strobe when `dout` goes 1->0.
- busy  output  1  high while a candidate level is being qualified.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports `clk`, `reset`).
- Reset values:
  - all sync flops = RESET_VAL; `dout` = RESET_VAL.
  - cnt = 0; state = STABLE.
  - `rise_pulse` = `fall_pulse` = `busy` = 0.
- Reset deassertion is synchronous to `clk` at system level; no internal reset synchronizer.
- Sync chain: `din` -> SYNC_STAGES flops -> `sync_q`. The chain always shifts, regardless of `en`.
- FSM states:
  - STABLE: `sync_q` == `dout`, cnt = 0.
  - QUALIFY: `sync_q` != `dout`, counting.
- Per clock edge, with `en` = 1:
  - `sync_q` == `dout`: state -> STABLE, cnt <= 0. A glitch is discarded with no output activity.
  - `sync_q` != `dout` and cnt >= `debounce_cnt`:
    - `dout` <= `sync_q`, cnt <= 0, state -> STABLE.
    - assert `rise_pulse` or `fall_pulse` per direction.
  - `sync_q` != `dout` and cnt < `debounce_cnt`: cnt <= cnt+1, state -> QUALIFY.
- Counter width rules:
  - cnt never exceeds `debounce_cnt` and never wraps.
  - The `>=` compare ensures that lowering `debounce_cnt` below the current cnt accepts the level on the next edge.
- Latency: a `din` change settled before edge k appears on `dout` after edge k+SYNC_STAGES+`debounce_cnt`. That is SYNC_STAGES+N+1 edges total; 6 for defaults with N=3.
- `debounce_cnt` = 0: `dout` follows `sync_q` one edge later; every sync'd change produces a pulse.
- `en` = 0:
  - cnt <= 0, state -> STABLE, `dout` holds, no pulses.
  - On re-enable, qualification restarts from cnt = 0.
- Outputs:
  - Pulses are registered, exactly one cycle wide, mutually exclusive, and coincide with the `dout` update edge.
  - `busy` = registered (state == QUALIFY).
- Reset mid-QUALIFY: all state returns to reset values immediately. The pending candidate is lost and no pulse is emitted.
- `din` toggling every cycle, with N >= 1: the sync'd value alternates, cnt keeps clearing, and `dout` never changes.

Decomposition:
- Package `pad_debounce_pkg`:
  - state enum {STABLE, QUALIFY}.
  - default constants DEF_SYNC_STAGES = 2 and DEF_CNT_W = 8.
- Sub-module `pad_sync_chain`:
  - parameterized SYNC_STAGES/RESET_VAL flop chain with async reset.
  - reusable by other pad-input paths.
- FSM, counter and pulse logic stay in the top module.

Test Plan:
1. Reset asserted with `din` = 1, RESET_VAL = 0 -> `dout` = 0, pulses = 0, `busy` = 0. After release with `din` = 1, N = 3: `dout` rises 6 edges later, `rise_pulse` high exactly 1 cycle.
2. N = 3, `din` high for 2 cycles then low -> `busy` pulses, `dout` stays 0, no `rise_pulse`. Same test with 4-cycle high -> `dout` = 1, then `fall_pulse` after the return-low is qualified.
3. N = 0, `din` square wave with period 4 cycles -> `dout` tracks with 3-edge lag (SYNC_STAGES+1); one pulse per transition.
4. N = 200, `en` dropped at cnt = 100, raised 10 cycles later with `din` still changed -> `dout` updates 201 edges after re-enable, not before.
5. QUALIFY at cnt = 5 with N = 10, `debounce_cnt` changed to 2 -> `dout` updates on the next edge with one pulse.
6. Reset asserted asynchronously (between edges) at cnt = 2 of N = 3 -> outputs return to reset values immediately; no pulse after release until a new full qualification.

Source files
------------

// File: rtl/pad_debounce_pkg.sv
// rtl/pad_debounce_pkg.sv - shared types and defaults for the pad input debounce path
package pad_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/pad_sync_chain.sv
// rtl/pad_sync_chain.sv - multi-flop synchronizer for an asynchronous pad level
module pad_sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync_q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_debounce.sv
// rtl/pad_input_debounce.sv - synchronizes a pad level, qualifies it for N+1 cycles, emits edge strobes
module pad_input_debounce
  import pad_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic [CNT_W-1:0] debounce_cnt,
  output logic             dout,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy
);

  logic             sync_q;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dout_nxt, rise_nxt, fall_nxt;

  pad_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .sync_q (sync_q)
  );

  // The >= compare lets a lowered threshold accept a candidate already past it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (!en) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else if (sync_q == dout) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
    end else if (cnt >= debounce_cnt) begin
      state_nxt = STABLE;
      cnt_nxt   = '0;
      dout_nxt  = sync_q;
      rise_nxt  = sync_q;
      fall_nxt  = ~sync_q;
    end else begin
      state_nxt = QUALIFY;
      cnt_nxt   = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE;
      cnt        <= '0;
      dout       <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      busy       <= (state_nxt == QUALIFY);
    end
  end

endmodule

// File: tb/tb_pad_input_debounce.sv
// tb/tb_pad_input_debounce.sv - scoreboard bench for pad_input_debounce edge events and levels
module tb_pad_input_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       din;
  logic [7:0] debounce_cnt;
  logic       dout, rise_pulse, fall_pulse, busy;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;
  ev_t exp_q[$];

  pad_input_debounce #(
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .din          (din),
    .debounce_cnt (debounce_cnt),
    .dout         (dout),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input bit rise);
    ev_t e;
    e.cyc  = at;
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  // Every strobe the DUT raises must match the next expected event.
  always @(negedge clk) begin
    if (rise_pulse || fall_pulse) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                 rise_pulse, fall_pulse, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_rise", int'(rise_pulse), int'(e.rise));
        check("pulse_fall", int'(fall_pulse), int'(!e.rise));
        check("pulse_dout", int'(dout), int'(e.rise));
      end
    end
  end

  initial begin
    int p;
    reset        = 1'b1;
    en           = 1'b1;
    din          = 1'b1;
    debounce_cnt = 8'd3;
    step(2);
    check("rst_dout", dout, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_busy", busy, 0);

    reset = 1'b0;
    p = cyc;
    expect_ev(p + 6, 1'b1);
    step(4);
    check("t1_dout_early", dout, 0);
    step(6);
    check("t1_dout", dout, 1);

    din = 1'b0;
    p = cyc;
    expect_ev(p + 6, 1'b0);
    step(10);
    check("t2_dout_low", dout, 0);

    din = 1'b1;
    step(2);
    din = 1'b0;
    step(1);
    check("t2_short_busy", busy, 1);
    step(10);
    check("t2_short_dout", dout, 0);
    check("t2_short_busy_end", busy, 0);

    din = 1'b1;
    p = cyc;
    expect_ev(p + 6, 1'b1);
    step(4);
    din = 1'b0;
    expect_ev(p + 10, 1'b0);
    step(12);
    check("t2_long_dout", dout, 0);

    debounce_cnt = 8'd0;
    for (int i = 0; i < 8; i++) begin
      din = ~din;
      expect_ev(cyc + 3, din);
      step(2);
    end
    step(6);
    check("t3_dout", dout, 0);

    debounce_cnt = 8'd200;
    din = 1'b1;
    p = cyc;
    step(102);
    check("t4_busy_before_dis", busy, 1);
    en = 1'b0;
    step(3);
    check("t4_busy_dis", busy, 0);
    check("t4_dout_dis", dout, 0);
    step(7);
    en = 1'b1;
    p = cyc;
    expect_ev(p + 201, 1'b1);
    step(200);
    check("t4_dout_not_early", dout, 0);
    step(1);
    check("t4_dout", dout, 1);
    step(5);

    debounce_cnt = 8'd10;
    din = 1'b0;
    p = cyc;
    step(5);
    check("t5_busy", busy, 1);
    step(2);
    check("t5_dout_before", dout, 1);
    debounce_cnt = 8'd2;
    expect_ev(p + 8, 1'b0);
    step(1);
    check("t5_dout", dout, 0);
    step(5);

    debounce_cnt = 8'd3;
    din = 1'b1;
    step(4);
    check("t6_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_busy_rst", busy, 0);
    check("t6_dout_rst", dout, 0);
    step(2);
    reset = 1'b0;
    p = cyc;
    expect_ev(p + 6, 1'b1);
    step(5);
    check("t6_dout_early", dout, 0);
    step(3);
    check("t6_dout", dout, 1);

    step(5);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
